scc_mem_responder: RTL
======================

Name: scc_mem_responder

Overview:
- Memory-side responder for the SCC core's two memory interfaces: the instruction fetch port (in_mem_addr/in_mem_en/in_mem) and the data port (data_addr/data_out/data_read/data_write/data_in).
- Word-organised single-port storage shared by both interfaces, with fixed programmable wait states and data-over-fetch arbitration.
- Returns a one-cycle valid/ack strobe per access so the core can stall on a slow memory.
- Sits beside SCC in the system top; used as the simulation and FPGA memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 0, extra cycles inserted before each response; range 0..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_mem_addr  input  32  fetch byte address from core.
- in_mem_en  input  1  fetch request; held high until in_mem_valid.
- in_mem  output  32  fetched instruction.
- in_mem_valid  output  1  one-cycle fetch-response strobe.
- data_addr  input  32  data byte address.
- data_out  input  32  store data from core.
- data_read  input  1  load request; held until data_valid.
- data_write  input  1  store request; held until data_valid.
- data_in  output  32  load data to core.
- data_valid  output  1  one-cycle load-data / store-ack strobe.
- fault  output  1  one-cycle strobe, coincident with valid, for a bad access.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, wait counter 0, in_mem=0, data_in=0, in_mem_valid=0, data_valid=0, fault=0.
- Reset does not clear storage contents. Reset mid-access aborts the access; a pending store is not committed.
- Word index = addr[log2(MEM_WORDS)+1:2].
- An access is bad if addr[1:0]!=0, addr >= 4*MEM_WORDS, or data_read and data_write are both high.
- FSM states:
  - IDLE: sample requests. If data_read or data_write is high, latch a DATA access; otherwise, if in_mem_en is high, latch a FETCH access. Latch address, write data and type. Go to WAIT when WAIT_CYCLES>0, else to RESP.
  - WAIT: counter increments from 0. Go to RESP when the counter reaches WAIT_CYCLES-1.
  - RESP: perform the array access and pulse the matching valid for one cycle, then return to IDLE.
- Latency: valid is high in the (WAIT_CYCLES+2)th cycle after the request is first sampled high.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Arbitration: a data request always wins when sampled together with a fetch. The fetch is serviced on the next IDLE sample, so its minimum latency is 2*(WAIT_CYCLES+2).
- Read data: in_mem/data_in update only on a read response and hold their value until the next response on that port.
- Store: the array word is written in the RESP cycle. data_valid is the ack; data_in is unchanged.
- Bad access: valid and fault pulse together. A read returns 0 and a write is suppressed.
- Request dropped early: latched values are used and the response is still issued; the core protocol forbids this.
- Read-after-write to the same word returns the new data, since accesses are serialised.

Optional Feature:
- Macro SCC_MEM_STATS_EN.
- Defined: adds three 32-bit output ports, stat_fetches, stat_loads and stat_stores.
  - Each counts completed, non-faulting accesses of its type.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- WAIT_CYCLES=0: store 0xDEADBEEF to 0x10 (ack 2 cycles after request), then load 0x10 -> data_valid on cycle 2, data_in=0xDEADBEEF, fault=0.
- WAIT_CYCLES=2: in_mem_en with in_mem_addr=0x0 (preloaded 0x12345678) -> in_mem_valid exactly 4 cycles after request, in_mem=0x12345678.
- Simultaneous fetch 0x4 and load 0x8, WAIT_CYCLES=1 -> data_valid at cycle 3, in_mem_valid at cycle 6; one strobe each, correct words.
- Load 0x13 (misaligned), then store to 4*MEM_WORDS -> fault with each valid, data_in=0, then readback of word 0 unchanged.
- Reset asserted in WAIT of a store to 0x20 (old value 0x1) -> all outputs 0 immediately; after release, load 0x20 returns 0x1.
- With SCC_MEM_STATS_EN: 3 fetches, 2 loads, 1 store, 1 faulting load -> stat_fetches=3, stat_loads=2, stat_stores=1.

Source files
------------

// File: rtl/scc_mem_responder.sv
//==============================================================================
// Module   : scc_mem_responder
// Purpose  : Memory-side responder for the SCC core. One word-organised
//            single-port array is shared by the instruction fetch port and
//            the data port. Data requests win over fetches. A fixed number of
//            wait states is inserted before each one-cycle valid/ack strobe.
//            Bad accesses (misaligned, out of range, or read+write together)
//            pulse fault together with valid. A bad read returns 0 and a bad
//            store is dropped.
// Options  : `define SCC_MEM_STATS_EN adds saturating counters for completed,
//            non-faulting fetches, loads and stores.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module scc_mem_responder #(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_mem_addr,
   input  logic        in_mem_en,
   output logic [31:0] in_mem,
   output logic        in_mem_valid,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_out,
   input  logic        data_read,
   input  logic        data_write,
   output logic [31:0] data_in,
   output logic        data_valid,
`ifdef SCC_MEM_STATS_EN
   output logic [31:0] stat_fetches,
   output logic [31:0] stat_loads,
   output logic [31:0] stat_stores,
`endif
   output logic        fault
);

   localparam int          AW           = $clog2(MEM_WORDS);
   localparam logic [31:0] c_ADDR_LIMIT = 32'(4 * MEM_WORDS);
   localparam logic [2:0]  c_WAIT_LAST  = 3'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          fetch_q, fetch_d;
   logic          we_q, we_d;
   logic          bad_q, bad_d;
   logic [31:0]   in_mem_q, in_mem_d;
   logic [31:0]   data_in_q, data_in_d;
   logic          in_valid_q, in_valid_d;
   logic          data_valid_q, data_valid_d;
   logic          fault_q, fault_d;

   logic [31:0]   mem_q [MEM_WORDS];
   logic [31:0]   w_rd_word;
   logic          w_mem_we;
   logic          w_fetch_bad;
   logic          w_data_bad;

   assign w_rd_word = mem_q[idx_q];

   // Classify the incoming request addresses before they are latched
   assign w_fetch_bad = (in_mem_addr[1:0] != 2'b00) || (in_mem_addr >= c_ADDR_LIMIT);
   assign w_data_bad  = (data_addr[1:0] != 2'b00) || (data_addr >= c_ADDR_LIMIT) ||
                        (data_read && data_write);

   // State and latched-request registers; reset aborts any access in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 3'd0;
         idx_q        <= '0;
         wdata_q      <= 32'd0;
         fetch_q      <= 1'b0;
         we_q         <= 1'b0;
         bad_q        <= 1'b0;
         in_mem_q     <= 32'd0;
         data_in_q    <= 32'd0;
         in_valid_q   <= 1'b0;
         data_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         wdata_q      <= wdata_d;
         fetch_q      <= fetch_d;
         we_q         <= we_d;
         bad_q        <= bad_d;
         in_mem_q     <= in_mem_d;
         data_in_q    <= data_in_d;
         in_valid_q   <= in_valid_d;
         data_valid_q <= data_valid_d;
         fault_q      <= fault_d;
      end
   end

   // Next-state, request latch and response generation
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      fetch_d      = fetch_q;
      we_d         = we_q;
      bad_d        = bad_q;
      in_mem_d     = in_mem_q;
      data_in_d    = data_in_q;
      in_valid_d   = 1'b0;
      data_valid_d = 1'b0;
      fault_d      = 1'b0;
      w_mem_we     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (data_read || data_write) begin
               idx_d   = data_addr[AW+1:2];
               wdata_d = data_out;
               fetch_d = 1'b0;
               // read+write together is treated as a (faulting) read
               we_d    = data_write && !data_read;
               bad_d   = w_data_bad;
               cnt_d   = 3'd0;
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end else if (in_mem_en) begin
               idx_d   = in_mem_addr[AW+1:2];
               fetch_d = 1'b1;
               we_d    = 1'b0;
               bad_d   = w_fetch_bad;
               cnt_d   = 3'd0;
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
         end

         S_WAIT: begin
            if (cnt_q == c_WAIT_LAST) begin
               cnt_d   = 3'd0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
            fault_d = bad_q;
            if (fetch_q) begin
               in_valid_d = 1'b1;
               in_mem_d   = bad_q ? 32'd0 : w_rd_word;
            end else begin
               data_valid_d = 1'b1;
               if (we_q) begin
                  w_mem_we = !bad_q;
               end else begin
                  data_in_d = bad_q ? 32'd0 : w_rd_word;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Storage array; deliberately not reset so contents survive a reset
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

`ifdef SCC_MEM_STATS_EN
   logic [31:0] st_fetch_q;
   logic [31:0] st_load_q;
   logic [31:0] st_store_q;

   // Saturating counters of completed, non-faulting accesses per type
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_fetch_q <= 32'd0;
         st_load_q  <= 32'd0;
         st_store_q <= 32'd0;
      end else if (state_q == S_RESP && !bad_q) begin
         if (fetch_q) begin
            if (st_fetch_q != 32'hFFFF_FFFF) st_fetch_q <= st_fetch_q + 32'd1;
         end else if (we_q) begin
            if (st_store_q != 32'hFFFF_FFFF) st_store_q <= st_store_q + 32'd1;
         end else begin
            if (st_load_q != 32'hFFFF_FFFF) st_load_q <= st_load_q + 32'd1;
         end
      end
   end

   assign stat_fetches = st_fetch_q;
   assign stat_loads   = st_load_q;
   assign stat_stores  = st_store_q;
`endif

   assign in_mem       = in_mem_q;
   assign in_mem_valid = in_valid_q;
   assign data_in      = data_in_q;
   assign data_valid   = data_valid_q;
   assign fault        = fault_q;

endmodule

`default_nettype wire
